// File: rtl/frame_wr_sched_pkg.sv
// rtl/frame_wr_sched_pkg.sv - shared frame-buffer constants, index type and scheduler state encoding
package frame_wr_sched_pkg;

    localparam int          IDX_W           = 3;
    localparam int          WORD_SHIFT      = 5;
    // 256 beats x 32 B: one burst step of the DDR3 write master
    localparam logic [31:0] CHUNK_BYTES_DEF = 32'd8192;

    typedef logic [IDX_W-1:0] buf_idx_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_BUSY      = 3'd3;
    localparam logic [2:0] ST_NEXT      = 3'd4;
    localparam logic [2:0] ST_PUBLISH   = 3'd5;

endpackage

// File: rtl/frame_wr_sched_if.sv
// rtl/frame_wr_sched_if.sv - write-job handshake between the scheduler and the DDR3 AXI write master
interface frame_wr_sched_if;

    logic        wr_start;
    logic [31:0] wr_adrs;
    logic [31:0] wr_len;
    logic        wr_ready;
    logic        wr_done;

    modport master (
        output wr_start,
        output wr_adrs,
        output wr_len,
        input  wr_ready,
        input  wr_done
    );

    modport slave (
        input  wr_start,
        input  wr_adrs,
        input  wr_len,
        output wr_ready,
        output wr_done
    );

endinterface

// File: rtl/fb_idx_next.sv
// rtl/fb_idx_next.sv - next frame-buffer index in the ring, stepping over the reader-locked buffer
module fb_idx_next
    import frame_wr_sched_pkg::*;
#(
    parameter int NUM_BUF = 4
) (
    input  buf_idx_t cur_idx,
    input  buf_idx_t lock_idx,
    output buf_idx_t next_idx
);

    localparam buf_idx_t MASK = buf_idx_t'(NUM_BUF - 1);

    buf_idx_t step1;
    buf_idx_t step2;

    always_comb begin
        step1    = (cur_idx + 3'd1) & MASK;
        step2    = (step1 + 3'd1) & MASK;
        next_idx = (step1 == lock_idx) ? step2 : step1;
    end

endmodule

// File: rtl/frame_wr_sched.sv
// rtl/frame_wr_sched.sv - cuts each video frame into fixed-size DDR3 write jobs and rotates frame buffers
module frame_wr_sched
    import frame_wr_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
    parameter int          NUM_BUF     = 4,
    parameter logic [31:0] FRAME_BYTES = 32'd8294400,
    parameter logic [31:0] CHUNK_BYTES = CHUNK_BYTES_DEF,
    parameter int          CNT_W       = 10
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic [CNT_W-1:0]     fifo_cnt,
    input  buf_idx_t             rd_lock_idx,
    frame_wr_sched_if.master     wr,
    output buf_idx_t             wr_buf_idx,
    output buf_idx_t             rd_buf_idx,
    output logic                 frame_done,
    output logic                 frame_drop
);

    logic [2:0]  state;
    logic [31:0] offset;
    logic [31:0] remain;
    logic        pending_restart;

    logic [31:0] job_len;
    logic [31:0] job_words;
    logic [31:0] buf_base;
    logic        data_ok;
    logic        in_frame;
    logic        restart_now;
    buf_idx_t    idx_next;

    fb_idx_next #(.NUM_BUF(NUM_BUF)) u_idx_next (
        .cur_idx  (wr_buf_idx),
        .lock_idx (rd_lock_idx),
        .next_idx (idx_next)
    );

    always_comb begin
        job_len     = (remain < CHUNK_BYTES) ? remain : CHUNK_BYTES;
        job_words   = job_len >> WORD_SHIFT;
        data_ok     = (32'(fifo_cnt) >= job_words) && wr.wr_ready;
        buf_base    = BASE_ADDR + BUF_STRIDE * 32'(wr_buf_idx);
        in_frame    = (state == ST_WAIT_DATA) || (state == ST_ISSUE) ||
                      (state == ST_BUSY) || (state == ST_NEXT);
        // a restart only lands between jobs so the master never sees an aborted burst
        restart_now = pending_restart && ((state == ST_WAIT_DATA) || (state == ST_NEXT));
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state           <= ST_IDLE;
            offset          <= 32'd0;
            remain          <= 32'd0;
            pending_restart <= 1'b0;
            wr.wr_start     <= 1'b0;
            wr.wr_adrs      <= 32'd0;
            wr.wr_len       <= 32'd0;
            wr_buf_idx      <= '0;
            rd_buf_idx      <= '0;
            frame_done      <= 1'b0;
            frame_drop      <= 1'b0;
        end else begin
            wr.wr_start     <= 1'b0;
            frame_done      <= 1'b0;
            frame_drop      <= 1'b0;
            pending_restart <= (pending_restart && !restart_now) ||
                               (in_frame && frame_start && enable);

            case (state)
                ST_IDLE: begin
                    if (frame_start && enable) begin
                        state  <= ST_WAIT_DATA;
                        offset <= 32'd0;
                        remain <= FRAME_BYTES;
                    end
                end
                ST_WAIT_DATA: begin
                    if (restart_now) begin
                        frame_drop <= 1'b1;
                        offset     <= 32'd0;
                        remain     <= FRAME_BYTES;
                    end else if (data_ok) begin
                        state       <= ST_ISSUE;
                        wr.wr_start <= 1'b1;
                        wr.wr_adrs  <= buf_base + offset;
                        wr.wr_len   <= job_len;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (wr.wr_done) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    state <= ST_WAIT_DATA;
                    if (restart_now) begin
                        frame_drop <= 1'b1;
                        offset     <= 32'd0;
                        remain     <= FRAME_BYTES;
                    end else begin
                        offset <= offset + wr.wr_len;
                        remain <= remain - wr.wr_len;
                        if (remain == wr.wr_len) begin
                            state      <= ST_PUBLISH;
                            frame_done <= 1'b1;
                            rd_buf_idx <= wr_buf_idx;
                        end
                    end
                end
                ST_PUBLISH: begin
                    wr_buf_idx <= idx_next;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_wr_sched.sv
// tb/tb_frame_wr_sched.sv - randomized self-checking bench for frame_wr_sched against a frame/job model
module tb_frame_wr_sched;
    import frame_wr_sched_pkg::*;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0080_0000;
    localparam int          NBUF   = 4;
    localparam int          FBYTES = 16416;
    localparam int          CHUNK  = 8192;

    logic       ACLK        = 1'b0;
    logic       ARESETN     = 1'b0;
    logic       enable      = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] fifo_cnt    = 10'd0;
    logic [2:0] rd_lock_idx = 3'd0;
    logic [2:0] wr_buf_idx;
    logic [2:0] rd_buf_idx;
    logic       frame_done;
    logic       frame_drop;

    frame_wr_sched_if wr_if ();

    frame_wr_sched #(
        .BASE_ADDR   (BASE),
        .BUF_STRIDE  (STRIDE),
        .NUM_BUF     (NBUF),
        .FRAME_BYTES (32'(FBYTES)),
        .CHUNK_BYTES (32'(CHUNK)),
        .CNT_W       (10)
    ) u_dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .frame_start (frame_start),
        .fifo_cnt    (fifo_cnt),
        .rd_lock_idx (rd_lock_idx),
        .wr          (wr_if),
        .wr_buf_idx  (wr_buf_idx),
        .rd_buf_idx  (rd_buf_idx),
        .frame_done  (frame_done),
        .frame_drop  (frame_drop)
    );

    always #5 ACLK = ~ACLK;

    int         errors = 0;
    int         checks = 0;
    int         t      = 0;
    logic [2:0] m_wr   = 3'd0;
    logic       saw_drop;
    logic       saw_done;
    logic       saw_start;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        t++;
        saw_drop  = saw_drop | frame_drop;
        saw_done  = saw_done | frame_done;
        saw_start = saw_start | wr_if.wr_start;
    endtask

    function automatic logic [2:0] model_next(input logic [2:0] cur, input logic [2:0] lock);
        logic [2:0] c;
        c = 3'((int'(cur) + 1) % NBUF);
        if (c == lock) c = 3'((int'(c) + 1) % NBUF);
        return c;
    endfunction

    task automatic set_inputs(input bit starve, input int need);
        if (!starve) begin
            fifo_cnt       = 10'(need + int'($urandom_range(0, 100)));
            wr_if.wr_ready = 1'b1;
        end else if ($urandom_range(0, 1) == 0) begin
            fifo_cnt       = 10'(need - 1);
            wr_if.wr_ready = 1'b1;
        end else begin
            fifo_cnt       = 10'(need + int'($urandom_range(0, 100)));
            wr_if.wr_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [2:0] lock, input int drop_job, input bit simul);
        int remain, off, len, need, k, lat, exp_t, job, dj;
        bit got, drop_due, inject;
        logic [31:0] exp_adrs;
        dj          = drop_job;
        rd_lock_idx = lock;
        remain      = FBYTES;
        off         = 0;
        job         = 0;
        drop_due    = 0;
        lat         = 2;
        len         = (remain < CHUNK) ? remain : CHUNK;
        need        = len / 32;
        k           = $urandom_range(0, 3);
        set_inputs(k > 0, need);
        saw_drop    = 0;
        saw_done    = 0;
        saw_start   = 0;
        enable      = 1'b1;
        frame_start = 1'b1;
        t           = 0;
        forever begin
            got = 0;
            while (!got && t < 12) begin
                tick();
                frame_start   = 1'b0;
                wr_if.wr_done = 1'b0;
                if (wr_if.wr_start) got = 1;
                else if (t == k) set_inputs(1'b0, need);
            end
            exp_t = (k + 1 > lat) ? k + 1 : lat;
            chk("start_lat", 64'(t), 64'(exp_t));
            if (!got) return;
            exp_adrs = BASE + STRIDE * 32'(m_wr) + 32'(off);
            chk("wr_adrs", 64'(wr_if.wr_adrs), 64'(exp_adrs));
            chk("wr_len", 64'(wr_if.wr_len), 64'(len));
            chk("drop_seen", 64'(saw_drop), 64'(drop_due));
            chk("no_done_mid", 64'(saw_done), 64'(0));
            saw_drop = 0;
            drop_due = 0;
            inject   = (job == dj);
            wr_if.wr_ready = 1'b0;
            fifo_cnt = 10'($urandom_range(0, 1023));
            tick();
            if (inject && !simul) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
            chk("adrs_hold", 64'(wr_if.wr_adrs), 64'(exp_adrs));
            wr_if.wr_done = 1'b1;
            if (inject && simul) frame_start = 1'b1;
            t   = 0;
            lat = 3;
            if (inject) begin
                remain   = FBYTES;
                off      = 0;
                job      = 0;
                drop_due = 1;
                dj       = -1;
            end else begin
                off    += len;
                remain -= len;
                job++;
            end
            if (remain == 0) break;
            len  = (remain < CHUNK) ? remain : CHUNK;
            need = len / 32;
            k    = $urandom_range(0, 3);
            set_inputs(k > 0, need);
        end
        tick();
        wr_if.wr_done = 1'b0;
        chk("done_early", 64'(frame_done), 64'(0));
        tick();
        chk("frame_done", 64'(frame_done), 64'(1));
        chk("rd_buf_idx", 64'(rd_buf_idx), 64'(m_wr));
        m_wr = model_next(m_wr, lock);
        tick();
        chk("wr_buf_idx", 64'(wr_buf_idx), 64'(m_wr));
        chk("done_pulse", 64'(frame_done), 64'(0));
        chk("no_drop", 64'(saw_drop), 64'(0));
        wr_if.wr_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dj;
        wr_if.wr_ready = 1'b1;
        wr_if.wr_done  = 1'b0;
        saw_drop = 0; saw_done = 0; saw_start = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_wr_start", 64'(wr_if.wr_start), 64'(0));
        chk("rst_wr_adrs", 64'(wr_if.wr_adrs), 64'(0));
        chk("rst_wr_len", 64'(wr_if.wr_len), 64'(0));
        chk("rst_idx", 64'({wr_buf_idx, rd_buf_idx}), 64'(0));
        chk("rst_pulses", 64'({frame_done, frame_drop}), 64'(0));
        ARESETN = 1'b1;
        tick();

        run_frame(3'd3, -1, 1'b0);

        saw_start = 0; saw_done = 0;
        wr_if.wr_done = 1'b1;
        tick();
        wr_if.wr_done = 1'b0;
        repeat (3) tick();
        chk("idle_done_start", 64'(saw_start), 64'(0));
        chk("idle_done_fd", 64'(saw_done), 64'(0));

        enable = 1'b0; fifo_cnt = 10'd500; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        chk("disabled_start", 64'(saw_start), 64'(0));

        run_frame(3'd3, -1, 1'b0);
        run_frame(3'd3, -1, 1'b0);
        run_frame(3'd1, -1, 1'b0);
        run_frame(3'd3, 0, 1'b0);
        run_frame(3'd3, 1, 1'b1);
        run_frame(3'd3, 2, 1'b1);

        for (int i = 0; i < 8; i++) begin
            dj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_frame(3'($urandom_range(0, 3)), dj, 1'($urandom_range(0, 1)));
        end

        saw_start = 0;
        rd_lock_idx = 3'd3; enable = 1'b1; fifo_cnt = 10'd300; wr_if.wr_ready = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_start", 64'(saw_start), 64'(1));
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_wr_start", 64'(wr_if.wr_start), 64'(0));
        chk("arst_adrs_len", 64'({wr_if.wr_adrs, wr_if.wr_len}), 64'(0));
        chk("arst_idx_pulses", 64'({wr_buf_idx, rd_buf_idx, frame_done, frame_drop}), 64'(0));
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_wr = 3'd0;
        saw_start = 0;
        repeat (8) tick();
        chk("post_rst_idle", 64'(saw_start), 64'(0));

        run_frame(3'd3, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_wr_sched.md
# frame_wr_sched

Upstream scheduler for the 256-bit DDR3 AXI write master in the frame buffer path. It counts pixel data accumulating in the write FIFO and cuts each video frame into fixed-size write jobs (WR_START/WR_ADRS/WR_LEN) for the master. It rotates frames through a ring of DDR3 frame buffers and publishes the index of the last complete frame to the read side. Each transfer is strictly one job at a time, gated by the master's WR_READY/WR_DONE handshake.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of buffer 0; 8192-byte aligned.
- BUF_STRIDE, 32'h0080_0000: byte distance between buffers; multiple of 8192.
- NUM_BUF, 4: buffer count, power of two, 2..8.
- FRAME_BYTES, 32'd8294400: bytes per frame; multiple of 32, ≤ BUF_STRIDE.
- CHUNK_BYTES, 32'd8192: bytes per job; multiple of 8192.
- CNT_W, 10: width of FIFO fill count.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- enable  in  1  level; when low, no new frame is accepted.
- frame_start  in  1  one-cycle pulse per incoming frame (ACLK domain).
- fifo_cnt  in  CNT_W  256-bit words currently in write FIFO.
- rd_lock_idx  in  3  buffer the reader currently owns; never written.
- wr_start  out  1  one-cycle job request to master.
- wr_adrs  out  32  job byte address.
- wr_len  out  32  job byte length.
- wr_ready  in  1  master idle.
- wr_done  in  1  master one-cycle completion pulse.
- wr_buf_idx  out  3  buffer being filled.
- rd_buf_idx  out  3  last complete buffer.
- frame_done  out  1  one-cycle pulse on frame publish.
- frame_drop  out  1  one-cycle pulse when a frame is abandoned.

## Operation
- States: IDLE, WAIT_DATA, ISSUE, BUSY, NEXT, PUBLISH.
- IDLE: on frame_start & enable, go to WAIT_DATA. On entry, offset = 0 and remain = FRAME_BYTES.
- WAIT_DATA: job_len = min(CHUNK_BYTES, remain). Advance to ISSUE when fifo_cnt ≥ job_len/32 and wr_ready = 1.
- ISSUE: drive wr_start = 1 for exactly one cycle. wr_adrs = BASE_ADDR + wr_buf_idx*BUF_STRIDE + offset. wr_len = job_len. Then go to BUSY.
- BUSY: wait for wr_done. Then go to NEXT.
- NEXT: offset += job_len and remain -= job_len. If remain = 0, go to PUBLISH; otherwise go to WAIT_DATA.
- PUBLISH:
  - rd_buf_idx ← wr_buf_idx; frame_done = 1.
  - wr_buf_idx ← (wr_buf_idx+1) mod NUM_BUF. If that buffer equals rd_lock_idx, skip one further.
  - Go to IDLE.
- frame_start while in WAIT_DATA, ISSUE, BUSY or NEXT: the in-flight job is never aborted. Set a pending_restart flag. At the next NEXT or WAIT_DATA boundary:
  - pulse frame_drop;
  - offset = 0, remain = FRAME_BYTES;
  - keep the same wr_buf_idx;
  - do not publish;
  - continue in WAIT_DATA.
- frame_start in PUBLISH or IDLE with enable = 0: ignored.
- enable falling mid-frame: the current frame completes normally.
- Arithmetic: all address and length math is 32-bit unsigned with no wrap checks (parameters guarantee range). Buffer index math is modulo NUM_BUF.

## Timing
- Reset values: all outputs 0; state IDLE; wr_buf_idx = 0; rd_buf_idx = 0; pending_restart = 0.
- wr_adrs and wr_len are registered. They are valid from the wr_start cycle and held stable until the next ISSUE.
- frame_start to first wr_start: ≥ 2 cycles (IDLE→WAIT_DATA→ISSUE) when the FIFO already holds enough data.
- wr_done to next wr_start: ≥ 3 cycles (NEXT, WAIT_DATA, ISSUE).
- frame_done is asserted 2 cycles after the final wr_done. rd_buf_idx updates in the same cycle as frame_done.
- wr_done while not in BUSY: ignored.
- Simultaneous frame_start and wr_done in BUSY: both take effect. The restart is applied in NEXT.

## Structure
- Shared frame-buffer package holds:
  - state encoding;
  - CHUNK_BYTES default (8192 = 256 beats × 32 B, matching the master's burst step);
  - 32-byte word shift constant 5;
  - buffer index width 3.
- The next-buffer selection (increment, modulo, lock skip) is a natural sub-module: fb_idx_next (combinational, reused by the read-side scheduler).

## Test plan
- FRAME_BYTES = 16384, fifo_cnt held at 512 → two jobs: adrs 0x0 len 8192, then adrs 0x2000 len 8192. frame_done follows; rd_buf_idx = 0, wr_buf_idx = 1.
- FRAME_BYTES = 8224 → jobs of len 8192 then len 32 at adrs 0x2000. The second job waits until fifo_cnt ≥ 1.
- fifo_cnt = 255 held → no wr_start. Raising fifo_cnt to 256 → wr_start within 1 cycle.
- rd_lock_idx = 1 with wr_buf_idx = 0 at publish → wr_buf_idx becomes 2. Four frames with lock 3 → sequence 0,1,2,0.
- Second frame_start during BUSY of job 1 → frame_drop pulse after that job's wr_done. Next wr_adrs = buffer base + 0; no frame_done.
- ARESETN low during BUSY → all outputs 0 immediately. After release, wr_start stays 0 until a new frame_start.
